// File: rtl/serial_adder_if.sv
// Start/done handshake and operand/result bus of the bit-serial adder.
// The master issues the operation; the slave is the adder itself.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             START;
    logic             SUB;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CIN;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] S;
    logic             COUT;
    logic             V;

    modport master (
        output START, SUB, A, B, CIN,
        input  BUSY, DONE, S, COUT, V
    );

    modport slave (
        input  START, SUB, A, B, CIN,
        output BUSY, DONE, S, COUT, V
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract: one full-adder cell (two half adders plus an OR)
// is reused LSB first over WIDTH cycles under a small IDLE/RUN/FIN FSM.
module serial_adder_ha (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic           CLK,
    input  logic           RST_N,
    serial_adder_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] res_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             ha0_s;
    logic             ha0_c;
    logic             sum_bit;
    logic             ha1_c;
    logic             carry_nxt;
    logic [WIDTH-1:0] res_nxt;
    logic             last_bit;
    logic             accept;

    serial_adder_ha u_ha0 (.a(a_sh[0]), .b(b_sh[0]), .s(ha0_s),   .c(ha0_c));
    serial_adder_ha u_ha1 (.a(ha0_s),   .b(carry),   .s(sum_bit), .c(ha1_c));

    assign carry_nxt = ha0_c | ha1_c;
    // Low WIDTH-1 result bits live in res_sh; the new sum bit enters at the MSB.
    assign res_nxt   = {sum_bit, res_sh};
    assign last_bit  = (cnt == CW'(WIDTH - 1));
    assign accept    = bus.START && (state == IDLE || state == FIN);

    assign bus.BUSY  = (state == RUN);
    assign bus.DONE  = (state == FIN);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            bus.S    <= '0;
            bus.COUT <= 1'b0;
            bus.V    <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_nxt[WIDTH-1:1];
                    carry  <= carry_nxt;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        // carry still holds the carry into the MSB at this edge
                        state    <= FIN;
                        bus.S    <= res_nxt;
                        bus.COUT <= carry_nxt;
                        bus.V    <= carry ^ carry_nxt;
                    end
                end
                IDLE, FIN: begin
                    if (accept) begin
                        state <= RUN;
                        a_sh  <= bus.A;
                        b_sh  <= bus.SUB ? ~bus.B : bus.B;
                        carry <= bus.SUB ? 1'b1 : bus.CIN;
                        cnt   <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH = 8 with hand-computed results.
module tb_serial_adder_ctrl;
    logic CLK;
    logic RST_N;
    int   n_cmp;
    int   n_err;

    serial_adder_if #(.WIDTH(8)) bus ();

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
        @(negedge CLK);
        bus.A     = a;
        bus.B     = b;
        bus.CIN   = cin;
        bus.SUB   = sub;
        bus.START = 1'b1;
        @(posedge CLK);
        #1 bus.START = 1'b0;
    endtask

    // Called just after the accepting edge; expects BUSY for 8 cycles, then DONE.
    task automatic wait_done(input string tag, input logic [7:0] prev_s, input logic [7:0] es,
                             input logic ec, input logic ev, input int inj, input bit chain);
        int lat = 0;
        int busy_n = 0;
        bit s_moved = 1'b0;
        bit overlap = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLK);
            if (bus.BUSY && bus.DONE) overlap = 1'b1;
            if (bus.BUSY) busy_n++;
            if (bus.DONE) begin
                lat = i;
                break;
            end
            if (bus.S !== prev_s) s_moved = 1'b1;
            if (i == inj) begin
                bus.START = 1'b1;
                bus.A     = 8'hAA;
                bus.B     = 8'h55;
            end else if (i == inj + 1) begin
                bus.START = 1'b0;
            end
        end
        chk({tag, "_latency"}, lat, 9);
        chk({tag, "_busy_cycles"}, busy_n, 8);
        chk({tag, "_busy_done_overlap"}, {31'd0, overlap}, 0);
        chk({tag, "_s_held"}, {31'd0, s_moved}, 0);
        chk({tag, "_s"}, {24'd0, bus.S}, {24'd0, es});
        chk({tag, "_cout"}, {31'd0, bus.COUT}, {31'd0, ec});
        chk({tag, "_v"}, {31'd0, bus.V}, {31'd0, ev});
        if (chain) begin
            bus.A     = 8'h10;
            bus.B     = 8'h20;
            bus.CIN   = 1'b0;
            bus.SUB   = 1'b0;
            bus.START = 1'b1;
        end
    endtask

    task automatic quiet_window(input string tag, input int cycles);
        int dones = 0;
        int busys = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge CLK);
            if (bus.DONE) dones++;
            if (bus.BUSY) busys++;
        end
        chk({tag, "_extra_done"}, dones, 0);
        chk({tag, "_extra_busy"}, busys, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        RST_N     = 1'b0;
        bus.START = 1'b0;
        bus.SUB   = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.CIN   = 1'b0;

        repeat (2) @(negedge CLK);
        chk("rst_busy", {31'd0, bus.BUSY}, 0);
        chk("rst_done", {31'd0, bus.DONE}, 0);
        chk("rst_s",    {24'd0, bus.S}, 0);
        chk("rst_cout", {31'd0, bus.COUT}, 0);
        chk("rst_v",    {31'd0, bus.V}, 0);
        RST_N = 1'b1;

        // Plain add, with a START pulse (0xAA/0x55) during RUN that must be ignored
        launch(8'h3C, 8'h0F, 1'b0, 1'b0);
        wait_done("add", 8'h00, 8'h4B, 1'b0, 1'b0, 3, 1'b0);
        quiet_window("add_ignored_start", 10);
        chk("add_s_after_idle", {24'd0, bus.S}, 32'h4B);

        launch(8'hFF, 8'h01, 1'b0, 1'b0);
        wait_done("add_wrap", 8'h4B, 8'h00, 1'b1, 1'b0, -5, 1'b0);
        launch(8'h7F, 8'h01, 1'b0, 1'b0);
        wait_done("add_ovf", 8'h00, 8'h80, 1'b0, 1'b1, -5, 1'b0);
        launch(8'h00, 8'h00, 1'b1, 1'b0);
        wait_done("add_cin", 8'h80, 8'h01, 1'b0, 1'b0, -5, 1'b0);
        launch(8'h05, 8'h07, 1'b1, 1'b1);
        wait_done("sub_borrow", 8'h01, 8'hFE, 1'b0, 1'b0, -5, 1'b0);
        launch(8'h80, 8'h01, 1'b0, 1'b1);
        wait_done("sub_ovf", 8'hFE, 8'h7F, 1'b1, 1'b1, -5, 1'b0);

        // Back-to-back: START raised during FIN with 0x10 + 0x20
        launch(8'h3C, 8'h0F, 1'b0, 1'b0);
        wait_done("b2b_first", 8'h7F, 8'h4B, 1'b0, 1'b0, -5, 1'b1);
        @(posedge CLK);
        #1 bus.START = 1'b0;
        wait_done("b2b_second", 8'h4B, 8'h30, 1'b0, 1'b0, -5, 1'b0);

        // Asynchronous reset in the 4th RUN cycle
        launch(8'h12, 8'h34, 1'b0, 1'b0);
        repeat (4) @(negedge CLK);
        #1 RST_N = 1'b0;
        #1;
        chk("arst_busy", {31'd0, bus.BUSY}, 0);
        chk("arst_done", {31'd0, bus.DONE}, 0);
        chk("arst_s",    {24'd0, bus.S}, 0);
        chk("arst_cout", {31'd0, bus.COUT}, 0);
        chk("arst_v",    {31'd0, bus.V}, 0);
        #2 RST_N = 1'b1;
        quiet_window("arst_after", 12);
        launch(8'h21, 8'h43, 1'b0, 1'b0);
        wait_done("post_rst", 8'h00, 8'h64, 1'b0, 1'b0, -5, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial add/subtract unit: one 1-bit full-adder cell (two HA instances plus an OR for carry) is reused over WIDTH clock cycles under FSM control, LSB first.
- Sits beside the CPU ALU as the low-area adder path.
- Start/done handshake toward the issuing logic; the result is held stable until the next operation completes.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous active-low reset
- START  input  1  request; sampled on CLK rising edge
- SUB  input  1  0 = A+B+CIN, 1 = A-B (A + ~B + 1; CIN ignored)
- A  input  WIDTH  operand A, captured on accepted START
- B  input  WIDTH  operand B, captured on accepted START
- CIN  input  1  carry-in for add, captured on accepted START
- BUSY  output  1  high while in RUN
- DONE  output  1  one-cycle completion pulse
- S  output  WIDTH  registered result
- COUT  output  1  registered carry-out; for SUB, 1 = no borrow
- V  output  1  registered signed overflow

Behaviour:
- Reset (RST_N low, asynchronous, any state):
  - state = IDLE.
  - BUSY, DONE, S, COUT, V all 0.
  - Operand shift registers, carry flop and bit counter all 0.
  - Takes effect immediately, mid-operation included; the partial result is discarded.
- States: IDLE, RUN, FIN.
- START is accepted when it is high at an edge and state is IDLE or FIN.
- On an accepted START:
  - Latch A, latch SUB ? ~B : B, and set the carry flop to SUB ? 1 : CIN.
  - Clear the bit counter; go to RUN.
- START while in RUN is ignored; operands and state are unaffected.
- RUN, each edge:
  - Full-adder cell computes sum and carry from the operand LSBs and the carry flop.
  - Sum bit shifts into the MSB of the internal result shift register; operand registers shift right; carry flop takes the new carry.
  - Before the MSB step (counter = WIDTH-1), the current carry is saved as carry-into-MSB.
  - Counter increments.
  - At the edge where counter = WIDTH-1 the last bit is processed, and the FSM goes to FIN.
- Entering FIN, all updated together on that same edge:
  - S = completed result.
  - COUT = final carry.
  - V = carry-into-MSB XOR final carry.
- FIN lasts exactly one cycle with DONE = 1, then returns to IDLE, unless START is accepted in that cycle, in which case it goes to RUN.
- Timing:
  - Accepted START at edge t0: BUSY = 1 after t0 through edge t0+WIDTH.
  - DONE = 1 for the single cycle following edge t0+WIDTH.
  - Latency START to DONE = WIDTH+1 edges; throughput one op per WIDTH+1 cycles.
- S/COUT/V change only on entry to FIN (or reset). They never expose partial bits, and hold their value through IDLE and the next RUN.
- BUSY and DONE are never high together.
- Arithmetic is modulo 2^WIDTH. No saturation.

Test Plan (WIDTH = 8):
1. Add: A=0x3C, B=0x0F, CIN=0, SUB=0, START at t0 -> BUSY high 8 cycles; DONE pulse after edge t0+8; S=0x4B, COUT=0, V=0.
2. Carry/overflow:
   - 0xFF+0x01, CIN=0 -> S=0x00, COUT=1, V=0.
   - 0x7F+0x01 -> S=0x80, COUT=0, V=1.
   - 0x00+0x00, CIN=1 -> S=0x01.
3. Subtract:
   - SUB=1, A=0x05, B=0x07, CIN=1 -> S=0xFE, COUT=0, V=0 (CIN ignored).
   - A=0x80, B=0x01 -> S=0x7F, COUT=1, V=1.
4. START ignored: pulse START with A=0xAA, B=0x55 during RUN of op 1 -> op 1 result 0x4B unchanged; DONE still after edge t0+8; no second DONE.
5. Back-to-back: START held high through FIN with new operands 0x10+0x20 -> DONE for op 1, then RUN again; second DONE after 9 more edges; S=0x30. S holds 0x4B until the second FIN.
6. Reset mid-op: RST_N low for one half-cycle at the 4th RUN cycle -> BUSY, DONE, S, COUT, V drop to 0 immediately (asynchronous); no DONE follows; a new START afterwards completes normally with a correct result.
